syn_gpu_mulberry_arbiter: RTL and testbench
===========================================

# syn_gpu_mulberry_arbiter

Arbitrates the shared mulberry multiply/divide engines among GPU requesters: Euclid (index 0), anti-aliaser (index 1), and any later clients. Each requester presents a service ID (SID) and a 32-bit operand word. The block grants one request at a time in round-robin order, launches the selected engine, and returns the engine result to the granted requester only. It sits between the GPU core clients and the mulberry MUL/DIV peripherals, and reports status to the LB.

## Interface
- P_NUM_REQ, 2, number of requesters (2..4)
- P_TIMEOUT, 255, max cycles to wait for an engine result before aborting
- clk_ir  in  1  system clock; single clock domain
- rst_sync  in  1  reset, synchronous, active-high
- req_sid  in  2*P_NUM_REQ  per-requester SID: 00 SID_IDLE, 01 SID_MUL, 10 SID_DIV, 11 reserved (treated as idle)
- req_data  in  32*P_NUM_REQ  per-requester operands: [31:16] operand A, [15:0] operand B
- req_rdy  out  P_NUM_REQ  one-cycle acceptance pulse to the granted requester
- res_valid  out  P_NUM_REQ  one-cycle result strobe to the granted requester
- res  out  32  result bus shared by all requesters; qualified by res_valid
- mul_start  out  1  one-cycle launch pulse to the multiplier
- div_start  out  1  one-cycle launch pulse to the divider
- eng_a, eng_b  out  16 each  registered operands A and B, stable from start until the result
- mul_res_valid, div_res_valid  in  1 each  engine completion strobes
- mul_res, div_res  in  32 each  engine results
- busy  out  1  high whenever the FSM is not in IDLE_S
- gnt_id  out  2  index of the current or last grant
- err_timeout  out  1  sticky timeout flag; cleared only by reset
- op_cnt  out  16  count of completed operations; wraps at 0xFFFF→0

## Operation
- FSM states: IDLE_S, ISSUE_S, WAIT_S, RESP_S.
- IDLE_S: a requester is eligible when its SID is 01 or 10. Search starts at rr_ptr and wraps modulo P_NUM_REQ; the first eligible index wins. On a hit:
  - latch the index into gnt_id, the op type, and eng_a/eng_b from that requester's req_data;
  - go to ISSUE_S.
- No eligible requester: stay in IDLE_S.
- ISSUE_S (one cycle): req_rdy[gnt_id]=1, and mul_start or div_start per op type. Reset the timeout counter, then go to WAIT_S.
- WAIT_S: only the valid strobe of the launched engine is observed. The other engine's strobe is ignored.
  - Strobe seen: capture that engine's result into res, then go to RESP_S.
  - Counter reaches P_TIMEOUT: res=0, set err_timeout, go to RESP_S.
  - Strobe and expiry in the same cycle: the strobe wins and err_timeout is not set.
- RESP_S (one cycle): res_valid[gnt_id]=1, op_cnt+1, rr_ptr=(gnt_id+1) mod P_NUM_REQ, then go to IDLE_S.
- One operation is outstanding at a time; there is no pipelining across requesters.
- A requester chains MUL then DIV by re-requesting after its res_valid. With the pointer advanced, a waiting peer is served first.
- A requester that drops its SID between IDLE_S and ISSUE_S still receives req_rdy; the operation completes anyway. Operands are already latched.
- res holds its value until the next capture. res_valid and req_rdy are 0 outside their single states.
- Reset (any state, including mid-operation):
  - FSM to IDLE_S; rr_ptr=0;
  - all outputs 0: req_rdy, res_valid, res, mul_start, div_start, eng_a, eng_b, busy, gnt_id, err_timeout, op_cnt.
  - An engine result arriving after reset is ignored.

## Timing
- Cycle 0: SID sampled eligible in IDLE_S.
- Cycle 1: ISSUE_S; req_rdy and start asserted.
- Engine result strobe in cycle k ≥ 2: res and res_valid are asserted in cycle k+1.
- Grant latency: 1 cycle from eligible SID to req_rdy.
- Result latency: 1 cycle from engine valid to requester res_valid.
- Back-to-back operations: minimum of 4 cycles per operation plus the engine latency. IDLE_S is always visited for one cycle between operations.
- Timeout abort: res_valid occurs P_TIMEOUT+2 cycles after ISSUE_S.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Single MUL from requester 1, req_data=0x0008_0010; multiplier returns 0x0000_0080 two cycles after start:
  - req_rdy[1] one cycle after SID=01;
  - eng_a=0x0008, eng_b=0x0010;
  - res_valid[1] with res=0x80;
  - req_rdy[0] and res_valid[0] stay 0; op_cnt=1.
- Both requesters assert SID=01 continuously from reset: grants alternate 0,1,0,1 over four operations, and each res_valid goes only to its granted index.
- Requester 1 chain, as used by the anti-aliaser:
  - MUL 0x00FF×0x0040 → res 0x3FC0;
  - then DIV with req_data=0x3FC0_0080 → div_start (not mul_start) → res_valid[1] with div_res passed unaltered.
- Divider never answers, P_TIMEOUT=255:
  - res_valid with res=0x0 at 257 cycles after ISSUE_S;
  - err_timeout=1 and stays 1 through later successful operations.
- Expiry and div_res_valid in the same cycle: res=div_res and err_timeout stays 0.
- Reset asserted in WAIT_S: next cycle all outputs are 0. A late mul_res_valid produces no res_valid. A fresh request from requester 0 is granted with the pointer starting at 0.

Source files
------------

// File: rtl/syn_gpu_mulberry_arbiter.sv
// syn_gpu_mulberry_arbiter
//
// Round-robin arbiter in front of the shared mulberry multiplier and divider.
// One operation is in flight at a time: a requester is picked in IDLE_S, the
// selected engine is launched in ISSUE_S, the engine result (or a timeout) is
// waited for in WAIT_S, and the result is returned in RESP_S.
//
// Ports
//   clk_ir, rst_sync        clock, synchronous active-high reset
//   req_sid, req_data       per-requester SID (2b) and operands (A=[31:16], B=[15:0])
//   req_rdy, res_valid      one-cycle per-requester accept / result strobes
//   res                     shared result bus, qualified by res_valid
//   mul_start, div_start    one-cycle engine launch pulses
//   eng_a, eng_b            latched operands for the engines
//   mul_/div_res_valid/res  engine completion strobes and results
//   busy, gnt_id            FSM not idle / index of current or last grant
//   err_timeout, op_cnt     sticky timeout flag / completed-operation count
// All outputs come straight from flops.

module syn_gpu_mulberry_arbiter #(
  parameter int unsigned P_NUM_REQ = 2,
  parameter int unsigned P_TIMEOUT = 255
) (
  input  logic                   clk_ir,
  input  logic                   rst_sync,
  input  logic [2*P_NUM_REQ-1:0] req_sid,
  input  logic [32*P_NUM_REQ-1:0] req_data,
  output logic [P_NUM_REQ-1:0]   req_rdy,
  output logic [P_NUM_REQ-1:0]   res_valid,
  output logic [31:0]            res,
  output logic                   mul_start,
  output logic                   div_start,
  output logic [15:0]            eng_a,
  output logic [15:0]            eng_b,
  input  logic                   mul_res_valid,
  input  logic                   div_res_valid,
  input  logic [31:0]            mul_res,
  input  logic [31:0]            div_res,
  output logic                   busy,
  output logic [1:0]             gnt_id,
  output logic                   err_timeout,
  output logic [15:0]            op_cnt
);

  localparam int unsigned CntW = (P_TIMEOUT < 2) ? 1 : $clog2(P_TIMEOUT + 1);

  typedef enum logic [1:0] {IdleS, IssueS, WaitS, RespS} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             rr_q, rr_d;
  logic [1:0]             gnt_q, gnt_d;
  logic                   op_div_q, op_div_d;
  logic [15:0]            eng_a_q, eng_a_d, eng_b_q, eng_b_d;
  logic [31:0]            res_q, res_d;
  logic                   err_q, err_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [15:0]            op_cnt_q, op_cnt_d;
  logic [P_NUM_REQ-1:0]   req_rdy_q, req_rdy_d, res_valid_q, res_valid_d;
  logic                   mul_start_q, mul_start_d, div_start_q, div_start_d;
  logic                   busy_q, busy_d;
  logic                   found;
  logic                   eng_done;
  logic [1:0]             sid_j;
  int unsigned            j;

  // Only the strobe of the launched engine counts.
  assign eng_done = op_div_q ? div_res_valid : mul_res_valid;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    op_div_d = op_div_q;
    eng_a_d  = eng_a_q;
    eng_b_d  = eng_b_q;
    res_d    = res_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    op_cnt_d = op_cnt_q;
    found    = 1'b0;
    sid_j    = 2'b00;
    j        = 0;

    unique case (state_q)
      IdleS: begin
        // Scan from rr_q upwards, wrapping; first SID of 01/10 wins.
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
          j = 32'(rr_q) + i;
          if (j >= P_NUM_REQ) j = j - P_NUM_REQ;
          sid_j = req_sid[2*j +: 2];
          if (!found && (sid_j == 2'b01 || sid_j == 2'b10)) begin
            found    = 1'b1;
            gnt_d    = 2'(j);
            op_div_d = sid_j[1];
            eng_a_d  = req_data[32*j+16 +: 16];
            eng_b_d  = req_data[32*j +: 16];
            state_d  = IssueS;
          end
        end
      end
      IssueS: begin
        cnt_d   = '0;
        state_d = WaitS;
      end
      WaitS: begin
        cnt_d = cnt_q + CntW'(1);
        // A strobe in the expiry cycle takes priority over the abort.
        if (eng_done) begin
          res_d   = op_div_q ? div_res : mul_res;
          state_d = RespS;
        end else if (cnt_q == CntW'(P_TIMEOUT)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RespS;
        end
      end
      RespS: begin
        op_cnt_d = op_cnt_q + 16'd1;
        rr_d     = (32'(gnt_q) + 1 >= P_NUM_REQ) ? 2'd0 : gnt_q + 2'd1;
        state_d  = IdleS;
      end
      default: state_d = IdleS;
    endcase

    // Outputs are registered from the next state so they line up with it.
    for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
      req_rdy_d[i]   = (state_d == IssueS) && (gnt_d == 2'(i));
      res_valid_d[i] = (state_d == RespS) && (gnt_d == 2'(i));
    end
    mul_start_d = (state_d == IssueS) && !op_div_d;
    div_start_d = (state_d == IssueS) && op_div_d;
    busy_d      = (state_d != IdleS);
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state_q     <= IdleS;
      rr_q        <= '0;
      gnt_q       <= '0;
      op_div_q    <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      op_cnt_q    <= '0;
      req_rdy_q   <= '0;
      res_valid_q <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      op_div_q    <= op_div_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      res_q       <= res_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      op_cnt_q    <= op_cnt_d;
      req_rdy_q   <= req_rdy_d;
      res_valid_q <= res_valid_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      busy_q      <= busy_d;
    end
  end

  assign req_rdy     = req_rdy_q;
  assign res_valid   = res_valid_q;
  assign res         = res_q;
  assign mul_start   = mul_start_q;
  assign div_start   = div_start_q;
  assign eng_a       = eng_a_q;
  assign eng_b       = eng_b_q;
  assign busy        = busy_q;
  assign gnt_id      = gnt_q;
  assign err_timeout = err_q;
  assign op_cnt      = op_cnt_q;

endmodule

// File: tb/tb_syn_gpu_mulberry_arbiter.sv
// Bench for syn_gpu_mulberry_arbiter: table of single operations, hand-written
// corner sequences (round robin, timeout, strobe/expiry race, mid-op reset) and
// a randomized run against a round-robin reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_syn_gpu_mulberry_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 255;

  logic              clk_ir = 1'b0;
  logic              rst_sync;
  logic [2*N-1:0]    req_sid;
  logic [32*N-1:0]   req_data;
  logic [N-1:0]      req_rdy, res_valid;
  logic [31:0]       res;
  logic              mul_start, div_start;
  logic [15:0]       eng_a, eng_b;
  logic              mul_res_valid, div_res_valid;
  logic [31:0]       mul_res, div_res;
  logic              busy;
  logic [1:0]        gnt_id;
  logic              err_timeout;
  logic [15:0]       op_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int   g_rr;
  int   g_opcnt;
  logic g_err;

  syn_gpu_mulberry_arbiter #(
    .P_NUM_REQ(N),
    .P_TIMEOUT(TO)
  ) dut (
    .clk_ir       (clk_ir),
    .rst_sync     (rst_sync),
    .req_sid      (req_sid),
    .req_data     (req_data),
    .req_rdy      (req_rdy),
    .res_valid    (res_valid),
    .res          (res),
    .mul_start    (mul_start),
    .div_start    (div_start),
    .eng_a        (eng_a),
    .eng_b        (eng_b),
    .mul_res_valid(mul_res_valid),
    .div_res_valid(div_res_valid),
    .mul_res      (mul_res),
    .div_res      (div_res),
    .busy         (busy),
    .gnt_id       (gnt_id),
    .err_timeout  (err_timeout),
    .op_cnt       (op_cnt)
  );

  always #5 clk_ir = ~clk_ir;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_ir);
    @(negedge clk_ir);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".z0"}, {res, eng_a, eng_b}, 64'd0);
    check({tag, ".z1"}, 64'({req_rdy, res_valid, mul_start, div_start, busy, gnt_id,
                             err_timeout, op_cnt}), 64'd0);
  endtask

  task automatic do_reset();
    rst_sync      = 1'b1;
    req_sid       = '0;
    mul_res_valid = 1'b0;
    div_res_valid = 1'b0;
    tick();
    tick();
    check_zero("rst");
    rst_sync = 1'b0;
    g_rr     = 0;
    g_opcnt  = 0;
    g_err    = 1'b0;
  endtask

  // Round-robin winner by the stated rule: search from the pointer, wrap mod N.
  function automatic int pick(input logic [2*N-1:0] s);
    for (int i = 0; i < int'(N); i++) begin
      int k;
      k = (g_rr + i) % int'(N);
      if (s[2*k +: 2] == 2'b01 || s[2*k +: 2] == 2'b10) return k;
    end
    return -1;
  endfunction

  // Called mid-cycle in IDLE with SIDs already driven. Engine answers lat
  // cycles after the ISSUE cycle.
  task automatic serve(input string tag, input int g, input logic dv, input logic [15:0] ea,
                       input logic [15:0] eb, input int lat, input logic [31:0] eres,
                       input logic noise, input logic [2*N-1:0] sid_after,
                       input logic [31:0] exp_res);
    logic [N-1:0] m;
    int           k;
    m      = '0;
    m[g]   = 1'b1;
    k      = 1 + lat;
    tick();
    check({tag, ".rdy"}, 64'(req_rdy), 64'(m));
    check({tag, ".gnt"}, 64'(gnt_id), 64'(g));
    check({tag, ".start"}, 64'({mul_start, div_start}), 64'({~dv, dv}));
    check({tag, ".eng"}, 64'({eng_a, eng_b}), 64'({ea, eb}));
    req_sid = sid_after;
    for (int c = 2; c <= k; c++) begin
      tick();
      if (c == 2) check({tag, ".pulse"}, 64'({req_rdy, mul_start, div_start}), 64'd0);
      check({tag, ".wait"}, 64'(res_valid), 64'd0);
      mul_res_valid = (!dv && c == k) || (dv && noise && c == 2 && c < k);
      div_res_valid = (dv && c == k) || (!dv && noise && c == 2 && c < k);
      mul_res       = dv ? 32'hDEAD_BEEF : eres;
      div_res       = dv ? eres : 32'hDEAD_BEEF;
    end
    tick();
    mul_res_valid = 1'b0;
    div_res_valid = 1'b0;
    check({tag, ".rv"}, 64'(res_valid), 64'(m));
    check({tag, ".res"}, 64'(res), 64'(exp_res));
    check({tag, ".err"}, 64'(err_timeout), 64'(g_err));
    g_opcnt = (g_opcnt + 1) % 65536;
    g_rr    = (g + 1) % int'(N);
    tick();
    check({tag, ".idle"}, 64'({res_valid, busy}), 64'd0);
    check({tag, ".opcnt"}, 64'(op_cnt), 64'(g_opcnt));
    check({tag, ".gnt_hold"}, 64'(gnt_id), 64'(g));
  endtask

  typedef struct {
    int          r;
    logic [1:0]  sid;
    logic [31:0] data;
    int          lat;
    logic [31:0] eres;
    logic        noise;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_div;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1, 2'b01, 32'h0008_0010, 2, 32'h0000_0080, 1'b0,
                16'h0008, 16'h0010, 1'b0, 32'h0000_0080};
    vecs[1] = '{1, 2'b01, 32'h00FF_0040, 3, 32'h0000_3FC0, 1'b1,
                16'h00FF, 16'h0040, 1'b0, 32'h0000_3FC0};
    vecs[2] = '{1, 2'b10, 32'h3FC0_0080, 4, 32'h0000_007F, 1'b1,
                16'h3FC0, 16'h0080, 1'b1, 32'h0000_007F};
    vecs[3] = '{0, 2'b10, 32'h1234_0005, 1, 32'h03A4_0000, 1'b0,
                16'h1234, 16'h0005, 1'b1, 32'h03A4_0000};
    vecs[4] = '{0, 2'b01, 32'hFFFF_FFFF, 5, 32'hFFFE_0001, 1'b1,
                16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};

    req_sid       = '0;
    req_data      = '0;
    mul_res_valid = 1'b0;
    div_res_valid = 1'b0;
    mul_res       = '0;
    div_res       = '0;
    rst_sync      = 1'b1;
    @(negedge clk_ir);
    do_reset();

    // Table of single operations, one requester active at a time
    foreach (vecs[i]) begin
      req_sid                        = '0;
      req_sid[2*vecs[i].r +: 2]      = vecs[i].sid;
      req_data[32*vecs[i].r +: 32]   = vecs[i].data;
      serve($sformatf("vec%0d", i), vecs[i].r, vecs[i].exp_div, vecs[i].exp_a, vecs[i].exp_b,
            vecs[i].lat, vecs[i].eres, vecs[i].noise, '0, vecs[i].exp_res);
    end

    // Reserved SID 11 is idle
    req_sid = {2'b11, 2'b11};
    tick();
    tick();
    check("reserved.busy", 64'({busy, req_rdy}), 64'd0);
    req_sid = '0;

    // Both requesting continuously from reset: grants 0,1,0,1
    do_reset();
    req_sid  = {2'b01, 2'b01};
    req_data = {32'h0003_0004, 32'h0001_0002};
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      serve($sformatf("rr%0d", i), g, 1'b0, (g == 1) ? 16'h0003 : 16'h0001,
            (g == 1) ? 16'h0004 : 16'h0002, 1 + i, 32'(i * 7 + 1), 1'b0, {2'b01, 2'b01},
            32'(i * 7 + 1));
    end
    req_sid = '0;

    // Divider never answers
    do_reset();
    req_sid[1:0]  = 2'b10;
    req_data[31:0] = 32'h0100_0002;
    tick();
    req_sid = '0;
    begin
      int cnt;
      cnt = 0;
      while (res_valid == '0 && cnt < 300) begin
        tick();
        cnt++;
      end
      check("to.latency", 64'(cnt), 64'(TO + 2));
      check("to.rv", 64'(res_valid), 64'd1);
      check("to.res", 64'(res), 64'd0);
      check("to.err", 64'(err_timeout), 64'd1);
    end
    g_err   = 1'b1;
    g_opcnt = 1;
    g_rr    = 1;
    tick();
    req_sid[3:2]    = 2'b01;
    req_data[63:32] = 32'h0002_0003;
    serve("to.after1", 1, 1'b0, 16'h0002, 16'h0003, 2, 32'h6, 1'b0, '0, 32'h6);
    req_sid[1:0]    = 2'b10;
    req_data[31:0]  = 32'h0009_0003;
    serve("to.after0", 0, 1'b1, 16'h0009, 16'h0003, 1, 32'h3, 1'b0, '0, 32'h3);

    // Strobe in the expiry cycle wins
    do_reset();
    req_sid[1:0] = 2'b10;
    tick();
    req_sid = '0;
    for (int i = 0; i < int'(TO) + 1; i++) tick();
    div_res_valid = 1'b1;
    div_res       = 32'h5555_AAAA;
    tick();
    div_res_valid = 1'b0;
    check("race.rv", 64'(res_valid), 64'd1);
    check("race.res", 64'(res), 64'h5555_AAAA);
    check("race.err", 64'(err_timeout), 64'd0);
    tick();

    // Reset in WAIT_S, late result ignored, pointer back at 0
    do_reset();
    req_sid[1:0]   = 2'b01;
    req_data[31:0] = 32'h0004_0005;
    serve("pre", 0, 1'b0, 16'h0004, 16'h0005, 1, 32'h14, 1'b0, '0, 32'h14);
    req_sid[3:2]    = 2'b01;
    req_data[63:32] = 32'h0006_0007;
    tick();
    req_sid = '0;
    tick();
    tick();
    check("midrst.busy_before", 64'(busy), 64'd1);
    rst_sync = 1'b1;
    tick();
    check_zero("midrst");
    rst_sync      = 1'b0;
    g_rr          = 0;
    g_opcnt       = 0;
    g_err         = 1'b0;
    mul_res_valid = 1'b1;
    mul_res       = 32'h0000_002A;
    tick();
    mul_res_valid = 1'b0;
    check("midrst.late", 64'({res_valid, busy}), 64'd0);
    req_sid  = {2'b01, 2'b01};
    req_data = {32'h0006_0007, 32'h0004_0005};
    serve("midrst.fresh", 0, 1'b0, 16'h0004, 16'h0005, 2, 32'h14, 1'b0, '0, 32'h14);

    // Randomized operations against the model
    for (int it = 0; it < 80; it++) begin
      logic [2*N-1:0] s;
      logic [2*N-1:0] sa;
      logic [31:0]    er;
      int             w;
      for (int r = 0; r < int'(N); r++) begin
        s[2*r +: 2]        = 2'($urandom_range(0, 3));
        req_data[32*r +: 32] = $urandom;
      end
      req_sid = s;
      w       = pick(s);
      if (w < 0) begin
        tick();
        check("rnd.noreq", 64'({busy, req_rdy}), 64'd0);
      end else begin
        er = $urandom;
        sa = (2*N)'($urandom);
        serve("rnd", w, s[2*w+1], req_data[32*w+16 +: 16], req_data[32*w +: 16],
              int'($urandom_range(1, 6)), er, 1'($urandom_range(0, 1)), sa, er);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
